// File: rtl/dmem_copy_engine.sv
// Block-copy master for the 256x8 data memory: moves len bytes src->dst, ascending.
// Ports: clk, rst (async, active-low), start/src/dst/len request; busy/done/err status;
// mem_a/mem_wd/mem_we/mem_rd memory port. Optional csum output under DMEM_COPY_CHECKSUM_EN.
module dmem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data_r;

    logic              accept;
    logic              ro_hit;
    logic [ADDR_W-1:0] idx_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign accept  = (state == IDLE) && start;
    assign idx_inc = idx + ADDR_W'(1);
    assign rd_addr = src_r + idx;
    assign wr_addr = dst_r + idx;
    // Top address is the memory's read-only cell.
    assign ro_hit  = (wr_addr == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_r  <= '0;
            dst_r  <= '0;
            len_r  <= '0;
            idx    <= '0;
            data_r <= '0;
            err    <= 1'b0;
`ifdef DMEM_COPY_CHECKSUM_EN
            csum   <= '0;
`endif
        end else begin
            if (accept) begin
                src_r <= src;
                dst_r <= dst;
                len_r <= len;
                idx   <= '0;
                err   <= 1'b0;
`ifdef DMEM_COPY_CHECKSUM_EN
                csum  <= '0;
`endif
            end
            if (state == READ) begin
                data_r <= mem_rd;
`ifdef DMEM_COPY_CHECKSUM_EN
                csum   <= csum ^ mem_rd;
`endif
            end
            if (state == WRITE) begin
                idx <= idx_inc;
                if (ro_hit) begin
                    err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy      = 1'b1;
                mem_a     = rd_addr;
                state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_a     = wr_addr;
                mem_wd    = data_r;
                mem_we    = !ro_hit;
                state_nxt = (idx_inc == len_r) ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine with a behavioural 256x8 memory.
// Directed copies: basic, zero length, wrap/read-only, overlap, ignored start, reset mid-op.
module tb_dmem_copy_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] mem_a;
    logic [7:0] mem_wd;
    logic       mem_we;
    logic [7:0] mem_rd;
`ifdef DMEM_COPY_CHECKSUM_EN
    logic [7:0] csum;
`endif

    logic [7:0] mem [256];
    logic       pl_we;
    logic [7:0] pl_a;
    logic [7:0] pl_d;
    int         we_cnt = 0;
    int         ff_cnt = 0;

    int total = 0;
    int bad   = 0;

    int dc;
    int bc;
    int nd;
    int we0;
    int ff0;

    always #5 clk = ~clk;

    dmem_copy_engine dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .mem_a (mem_a),
        .mem_wd(mem_wd),
        .mem_we(mem_we),
        .mem_rd(mem_rd)
`ifdef DMEM_COPY_CHECKSUM_EN
        ,
        .csum  (csum)
`endif
    );

    assign mem_rd = mem[mem_a];

    // 0xFF is read-only in the real memory; the model also refuses it.
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_a] <= pl_d;
        end else if (mem_we && mem_a != 8'hFF) begin
            mem[mem_a] <= mem_wd;
        end
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_we && mem_a == 8'hFF) ff_cnt <= ff_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the accepting edge. inj>0 pulses a
    // junk start in that cycle, which must be ignored.
    task automatic run(input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] l, input int inj,
                       output int dcyc, output int bcnt, output int ndone);
        dcyc  = -1;
        bcnt  = 0;
        ndone = 0;
        @(negedge clk);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            if (busy) bcnt++;
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
            end
            if (c == inj) begin
                src   = 8'h77;
                dst   = 8'h88;
                len   = 8'h09;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (dcyc >= 0 && c >= dcyc + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        src   = 8'h00;
        dst   = 8'h00;
        len   = 8'h00;
        pl_we = 1'b0;
        pl_a  = 8'h00;
        pl_d  = 8'h00;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_mem_a", int'(mem_a), 0);
        check("rst_mem_wd", int'(mem_wd), 0);
        check("rst_mem_we", int'(mem_we), 0);
`ifdef DMEM_COPY_CHECKSUM_EN
        check("rst_csum", int'(csum), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic copy
        poke(8'h10, 8'hA1);
        poke(8'h11, 8'hB2);
        poke(8'h12, 8'hC3);
        poke(8'h13, 8'hD4);
        for (int i = 0; i < 4; i++) poke(8'h40 + 8'(i), 8'h00);
        run(8'h10, 8'h40, 8'd4, 0, dc, bc, nd);
        check("basic_done_cyc", dc, 9);
        check("basic_busy_cyc", bc, 8);
        check("basic_ndone", nd, 1);
        check("basic_m40", int'(mem[8'h40]), 'hA1);
        check("basic_m41", int'(mem[8'h41]), 'hB2);
        check("basic_m42", int'(mem[8'h42]), 'hC3);
        check("basic_m43", int'(mem[8'h43]), 'hD4);
        check("basic_err", int'(err), 0);
`ifdef DMEM_COPY_CHECKSUM_EN
        check("basic_csum", int'(csum), 'h04);
`endif

        // Zero length
        poke(8'h50, 8'h99);
        we0 = we_cnt;
        run(8'h10, 8'h50, 8'd0, 0, dc, bc, nd);
        check("zero_done_cyc", dc, 1);
        check("zero_busy_cyc", bc, 0);
        check("zero_we", we_cnt - we0, 0);
        check("zero_m50", int'(mem[8'h50]), 'h99);

        // Wrap through the read-only cell
        poke(8'h00, 8'h11);
        poke(8'h01, 8'h22);
        poke(8'h02, 8'h33);
        poke(8'hFE, 8'h00);
        poke(8'hFF, 8'hAB);
        ff0 = ff_cnt;
        we0 = we_cnt;
        run(8'h00, 8'hFE, 8'd3, 0, dc, bc, nd);
        check("wrap_done_cyc", dc, 7);
        check("wrap_mFE", int'(mem[8'hFE]), 'h11);
        check("wrap_m00", int'(mem[8'h00]), 'h33);
        check("wrap_mFF", int'(mem[8'hFF]), 'hAB);
        check("wrap_ff_we", ff_cnt - ff0, 0);
        check("wrap_we", we_cnt - we0, 2);
        check("wrap_err", int'(err), 1);
`ifdef DMEM_COPY_CHECKSUM_EN
        check("wrap_csum", int'(csum), 'h00);
`endif

        // Overlap: first byte replicates; this start also clears err
        poke(8'h20, 8'h5A);
        for (int i = 1; i <= 4; i++) poke(8'h20 + 8'(i), 8'h00);
        run(8'h20, 8'h21, 8'd4, 0, dc, bc, nd);
        check("ovl_err_clr", int'(err), 0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovl_m%0h", 8'h20 + i), int'(mem[8'h20 + 8'(i)]), 'h5A);
        end

        // Start during busy is ignored
        poke(8'h30, 8'h01);
        poke(8'h31, 8'h02);
        poke(8'h32, 8'h03);
        for (int i = 0; i < 3; i++) poke(8'h60 + 8'(i), 8'h00);
        poke(8'h88, 8'h5E);
        run(8'h30, 8'h60, 8'd3, 2, dc, bc, nd);
        check("ign_done_cyc", dc, 7);
        check("ign_ndone", nd, 1);
        check("ign_m60", int'(mem[8'h60]), 'h01);
        check("ign_m61", int'(mem[8'h61]), 'h02);
        check("ign_m62", int'(mem[8'h62]), 'h03);
        check("ign_m88", int'(mem[8'h88]), 'h5E);

        // Reset during the write of byte 2 of a len=5 copy
        for (int i = 0; i < 5; i++) begin
            poke(8'h70 + 8'(i), 8'h10 * 8'(i + 1));
            poke(8'h90 + 8'(i), 8'hEE);
        end
        @(negedge clk);
        src   = 8'h70;
        dst   = 8'h90;
        len   = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("rmid_we_before", int'(mem_we), 1);
        check("rmid_a_before", int'(mem_a), 'h92);
        rst = 1'b0;
        #1;
        check("rmid_we_async", int'(mem_we), 0);
        check("rmid_busy_async", int'(busy), 0);
        check("rmid_done_async", int'(done), 0);
        @(negedge clk);
        check("rmid_done_hold", int'(done), 0);
        rst = 1'b1;
        check("rmid_m90", int'(mem[8'h90]), 'h10);
        check("rmid_m91", int'(mem[8'h91]), 'h20);
        check("rmid_m92", int'(mem[8'h92]), 'hEE);
        check("rmid_m93", int'(mem[8'h93]), 'hEE);
        check("rmid_m94", int'(mem[8'h94]), 'hEE);
        poke(8'hA0, 8'h00);
        run(8'h70, 8'hA0, 8'd1, 0, dc, bc, nd);
        check("post_done_cyc", dc, 3);
        check("post_busy_cyc", bc, 2);
        check("post_mA0", int'(mem[8'hA0]), 'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
